// File: rtl/chu_gpo_seq.sv
// MMIO slot core driving the LED/GPO bus either from a manual register or
// from an autonomous pattern sequencer (one-shot or looped).
module chu_gpo_seq #(
    parameter int W  = 11,
    parameter int N  = 8,
    parameter int PW = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] dout
);
    localparam int         IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [4:0] LEN_MAX = 5'(N);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t r_state, w_state_nxt;

    logic [W-1:0]  r_manual, r_dout;
    logic [W-1:0]  r_pat [N];
    logic [11:0]   r_dur [N];
    logic [PW-1:0] r_p, r_pre;
    logic [4:0]    r_len;
    logic [3:0]    r_step;
    logic [11:0]   r_dcnt;
    logic          r_loop, r_done;

    logic          w_wr_en, w_go, w_stop, w_clr, w_ent_ok, w_ent_wr;
    logic          w_tick, w_expire, w_last, w_start, w_finish;
    logic [IW-1:0] w_cur, w_nxt, w_ent_idx;
    logic [11:0]   w_dur_eff;
    logic [4:0]    w_len_eff;
    logic [W-1:0]  w_manual_nxt;
    logic          w_unused;

    assign w_unused = ^{read, wr_data, r_step};
    assign dout     = r_dout;

    always_comb begin
        w_wr_en      = cs & write;
        w_go         = w_wr_en && (addr == 5'd0) && wr_data[0];
        w_stop       = w_wr_en && (addr == 5'd0) && wr_data[2];
        w_clr        = w_wr_en && (addr == 5'd0) && wr_data[3];
        w_ent_idx    = addr[IW-1:0];
        w_ent_ok     = addr[4] && ({1'b0, addr[3:0]} < LEN_MAX);
        w_ent_wr     = w_wr_en && w_ent_ok;
        w_manual_nxt = (w_wr_en && (addr == 5'd1)) ? wr_data[W-1:0] : r_manual;
        w_cur        = r_step[IW-1:0];
        w_nxt        = w_cur + IW'(1);
        w_dur_eff    = (r_dur[w_cur] == 12'd0) ? 12'd1 : r_dur[w_cur];
        w_len_eff    = (r_len == 5'd0) ? 5'd1 : ((r_len > LEN_MAX) ? LEN_MAX : r_len);
        w_tick       = (r_pre == r_p);
        // >= so a duration shortened below the running count expires at once
        w_expire     = w_tick && (r_dcnt >= w_dur_eff - 12'd1);
        w_last       = ({1'b0, r_step} >= w_len_eff - 5'd1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go && !w_stop) begin
                    w_state_nxt = S_RUN;
                    w_start     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_go) begin
                    w_start = 1'b1;
                end else if (w_expire && w_last && !r_loop) begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_manual <= '0;
            r_p      <= '0;
            r_len    <= '0;
            r_loop   <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                r_pat[i] <= '0;
                r_dur[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                case (addr)
                    5'd0:    r_loop   <= wr_data[1];
                    5'd1:    r_manual <= wr_data[W-1:0];
                    5'd2:    r_p      <= wr_data[PW-1:0];
                    5'd3:    r_len    <= wr_data[4:0];
                    default: ;
                endcase
            end
            if (w_ent_wr) begin
                r_pat[w_ent_idx] <= wr_data[W-1:0];
                r_dur[w_ent_idx] <= wr_data[27:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= '0;
            r_pre  <= '0;
            r_dcnt <= '0;
            r_dout <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_start)       r_done <= 1'b0;
            else if (w_finish) r_done <= 1'b1;
            else if (w_clr)    r_done <= 1'b0;

            if (w_start) begin
                r_step <= '0;
                r_pre  <= '0;
                r_dcnt <= '0;
                r_dout <= r_pat[0];
            end else if (w_state_nxt == S_IDLE) begin
                r_dout <= w_manual_nxt;
            end else begin
                r_pre <= w_tick ? '0 : r_pre + PW'(1);
                if (w_expire) begin
                    r_dcnt <= '0;
                    if (w_last) begin
                        r_step <= '0;
                        r_dout <= r_pat[0];
                    end else begin
                        r_step <= r_step + 4'd1;
                        r_dout <= r_pat[w_nxt];
                    end
                end else if (w_tick) begin
                    r_dcnt <= r_dcnt + 12'd1;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr[4]) begin
            if (w_ent_ok) begin
                rd_data[27:16] = r_dur[w_ent_idx];
                rd_data[W-1:0] = r_pat[w_ent_idx];
            end
        end else begin
            case (addr)
                5'd0:    rd_data[7:0]    = {r_step, 1'b0, r_loop, r_done, r_state == S_RUN};
                5'd1:    rd_data[W-1:0]  = r_manual;
                5'd2:    rd_data[PW-1:0] = r_p;
                5'd3:    rd_data[4:0]    = r_len;
                5'd4:    rd_data[W-1:0]  = r_dout;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chu_gpo_seq.sv
// Directed bench for chu_gpo_seq: stimulus queues expected values, a
// negedge monitor pops and compares them against dout / rd_data.
module tb_chu_gpo_seq;
    logic        clk = 1'b0;
    logic        reset, cs, rd, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic [10:0] dout;

    always #5 clk = ~clk;

    chu_gpo_seq #(.W(11), .N(8), .PW(24)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(rd), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .dout(dout)
    );

    typedef struct {
        bit          cd;
        logic [10:0] d;
        bit          cr;
        logic [31:0] r;
        logic [31:0] m;
    } exp_t;

    exp_t  sb[$];
    string sb_nm[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // 3-entry table, P=1: 0x001 x4, 0x002 x2, 0x004 x6 cycles
    logic [10:0] pat3 [12] = '{11'h1, 11'h1, 11'h1, 11'h1, 11'h2, 11'h2,
                               11'h4, 11'h4, 11'h4, 11'h4, 11'h4, 11'h4};

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            nm = sb_nm.pop_front();
            if (e.cd) begin
                n_cmp++;
                if (dout !== e.d) begin
                    n_bad++;
                    $display("FAIL %s: dout=%h expected %h (t=%0t)", nm, dout, e.d, $time);
                end
            end
            if (e.cr) begin
                n_cmp++;
                if ((rd_data & e.m) !== e.r) begin
                    n_bad++;
                    $display("FAIL %s: rd_data=%h expected %h mask %h (t=%0t)",
                             nm, rd_data, e.r, e.m, $time);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push(string nm, bit cd, logic [10:0] d, bit cr, logic [4:0] a,
                        logic [31:0] r, logic [31:0] m);
        exp_t e;
        e.cd = cd; e.d = d; e.cr = cr; e.r = r; e.m = m;
        if (cr) addr = a;
        sb.push_back(e);
        sb_nm.push_back(nm);
    endtask

    task automatic ck_d(string nm, logic [10:0] d);
        push(nm, 1'b1, d, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic ck_r(string nm, logic [4:0] a, logic [31:0] r, logic [31:0] m);
        push(nm, 1'b0, 11'h0, 1'b1, a, r, m);
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        nxt();
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic seq_chk(string nm, int n, int start);
        for (int i = 0; i < n; i++) begin
            ck_d(nm, pat3[(start + i) % 12]);
            nxt();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] v;
        reset = 1'b1; cs = 1'b0; rd = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'h0;
        nxt(); nxt();
        ck_d("rst_dout", 11'h0);
        ck_r("rst_ctrl", 5'd0, 32'h0, '1);
        nxt();
        reset = 1'b0;
        nxt();

        // manual mode latency
        ck_d("man_before", 11'h0);
        wr(5'd1, 32'h5A5);
        ck_d("man_dout", 11'h5A5);
        ck_r("man_rd4", 5'd4, 32'h5A5, '1);
        nxt();

        // one-shot 3-step sequence
        wr(5'd2, 32'd1);
        wr(5'd3, 32'd3);
        wr(5'd16, 32'h0002_0001);
        wr(5'd17, 32'h0001_0002);
        wr(5'd18, 32'h0003_0004);
        ck_r("ent0_rd", 5'd16, 32'h0002_0001, '1);
        nxt();
        wr(5'd0, 32'h1);
        ck_r("os_ctrl0", 5'd0, 32'h01, '1);
        seq_chk("oneshot", 4, 0);
        ck_r("os_ctrl1", 5'd0, 32'h11, '1);
        seq_chk("oneshot", 2, 4);
        ck_r("os_ctrl2", 5'd0, 32'h21, '1);
        seq_chk("oneshot", 6, 6);
        ck_d("os_end", 11'h5A5);
        ck_r("os_done", 5'd0, 32'h2, 32'hF);
        nxt();
        ck_d("os_end2", 11'h5A5);
        nxt();

        // looped, then stop in the middle of step 2
        wr(5'd0, 32'h3);
        seq_chk("loop", 31, 0);
        ck_d("stop_pre", 11'h4);
        wr(5'd0, 32'h6);
        ck_d("stop_dout", 11'h5A5);
        ck_r("stop_ctrl", 5'd0, 32'h24, '1);
        nxt();

        // L=0, D=0, P=0: one single-cycle step
        wr(5'd2, 32'd0);
        wr(5'd3, 32'd0);
        wr(5'd16, 32'h0000_0077);
        wr(5'd0, 32'h1);
        ck_d("l0_step", 11'h077);
        nxt();
        ck_d("l0_end", 11'h5A5);
        ck_r("l0_done", 5'd0, 32'h2, 32'hF);
        nxt();

        // L=20 clamps to N=8 steps
        wr(5'd3, 32'd20);
        for (int i = 0; i < 8; i++) wr(5'(16 + i), 32'd1 << i);
        wr(5'd0, 32'h1);
        for (int i = 0; i < 8; i++) begin
            v = 11'd1 << i;
            ck_d("l20_step", v);
            nxt();
        end
        ck_d("l20_end", 11'h5A5);
        nxt();
        wr(5'd24, 32'hFFFF_FFFF);
        ck_r("oob_rd", 5'd24, 32'h0, '1);
        nxt();
        ck_r("ent7_rd", 5'd23, 32'h80, '1);
        nxt();
        ck_r("len_rd", 5'd3, 32'd20, '1);
        nxt();

        // go|stop in IDLE stays idle; go|clr_done starts and clears done
        wr(5'd0, 32'h5);
        ck_d("gostop_dout", 11'h5A5);
        ck_r("gostop_busy", 5'd0, 32'h0, 32'h1);
        nxt();
        wr(5'd2, 32'd2);
        wr(5'd0, 32'h9);
        ck_r("goclr_ctrl", 5'd0, 32'h1, 32'h3);
        ck_d("goclr_d", 11'h1);
        nxt();
        ck_d("goclr_d", 11'h1); nxt();
        ck_d("goclr_d", 11'h1); nxt();
        ck_d("goclr_d", 11'h2); nxt();
        ck_d("restart_pre", 11'h2);
        wr(5'd0, 32'h1);
        for (int i = 0; i < 7; i++) begin
            v = (i < 3) ? 11'h1 : ((i < 6) ? 11'h2 : 11'h4);
            ck_d("restart", v);
            nxt();
        end

        // reset during a looping run
        wr(5'd0, 32'h3);
        nxt(); nxt();
        reset = 1'b1;
        nxt();
        ck_d("rr_dout", 11'h0);
        ck_r("rr_ctrl", 5'd0, 32'h0, '1);
        reset = 1'b0;
        nxt();
        ck_d("rr_dout2", 11'h0);
        ck_r("rr_man", 5'd1, 32'h0, '1);
        nxt();
        ck_r("rr_p", 5'd2, 32'h0, '1); nxt();
        ck_r("rr_len", 5'd3, 32'h0, '1); nxt();
        ck_r("rr_ent0", 5'd16, 32'h0, '1); nxt();
        ck_r("rr_ctrl2", 5'd0, 32'h0, '1); nxt();
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
